// File: rtl/loader_pkg.sv
// Shared types and constants for the serial boot loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CNT_HI   = 3'd1,
    CNT_LO   = 3'd2,
    DATA_HI  = 3'd3,
    DATA_LO  = 3'd4,
    SET_ADDR = 3'd5,
    WRITE    = 3'd6,
    CHECK    = 3'd7
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         CHK_W         = 8;

  function automatic logic [CHK_W-1:0] chk_update(input logic [CHK_W-1:0] chk,
                                                  input logic [7:0]       b);
    return chk ^ b;
  endfunction

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte idle counter; expired is high during the last allowed idle cycle.
module byte_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_r;

  // Idle-cycle counter, held at its limit until cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (run && (cnt_r != LAST)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = run && (cnt_r == LAST);

endmodule

// File: rtl/mem_loader.sv
// Serial boot loader: frames UART bytes into 16-bit words and writes them to
// memory via its address-register / write-enable interface.
module mem_loader
  import loader_pkg::*;
#(
  parameter int          MEM_SIZE       = 256,
  parameter logic [15:0] BASE_ADDR      = 16'h0000,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        mem_addr_en,
  output logic [15:0] mem_addr,
  output logic        mem_in_en,
  output logic [15:0] mem_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  localparam logic [16:0] LIMIT = 17'(MEM_SIZE - int'(BASE_ADDR));

  state_t            st_r, st_nxt;
  logic [15:0]       cnt_r, idx_r, word_r;
  logic [CHK_W-1:0]  chk_r;
  logic [15:0]       cnt_full_s;
  logic              acc_s, tmo_s, abort_s, timed_s, tmo_clr_s, oversize_s;

  assign acc_s      = rx_valid && rx_ready;
  assign cnt_full_s = {cnt_r[15:8], rx_data};
  assign oversize_s = {1'b0, cnt_full_s} > LIMIT;
  assign timed_s    = (st_r == CNT_HI) || (st_r == CNT_LO) || (st_r == DATA_HI) ||
                      (st_r == DATA_LO) || (st_r == CHECK);
  // A byte arriving in the final idle cycle still counts as on time
  assign abort_s    = tmo_s && !acc_s;
  assign tmo_clr_s  = acc_s || (st_nxt != st_r);

  byte_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr_s),
    .run     (timed_s),
    .expired (tmo_s)
  );

  // Frame state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_r <= IDLE;
    end else begin
      st_r <= st_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    st_nxt = st_r;
    if (abort_s) begin
      st_nxt = IDLE;
    end else begin
      case (st_r)
        IDLE:     st_nxt = (acc_s && (rx_data == SYNC_BYTE)) ? CNT_HI : IDLE;
        CNT_HI:   st_nxt = acc_s ? CNT_LO : CNT_HI;
        CNT_LO: begin
          if (!acc_s)                    st_nxt = CNT_LO;
          else if (oversize_s)           st_nxt = IDLE;
          else if (cnt_full_s == 16'd0)  st_nxt = CHECK;
          else                           st_nxt = DATA_HI;
        end
        DATA_HI:  st_nxt = acc_s ? DATA_LO : DATA_HI;
        DATA_LO:  st_nxt = acc_s ? SET_ADDR : DATA_LO;
        SET_ADDR: st_nxt = WRITE;
        WRITE:    st_nxt = ((idx_r + 16'd1) == cnt_r) ? CHECK : DATA_HI;
        CHECK:    st_nxt = acc_s ? IDLE : CHECK;
        default:  st_nxt = IDLE;
      endcase
    end
  end

  // Handshake and memory strobes registered from the upcoming state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready    <= 1'b0;
      mem_addr_en <= 1'b0;
      mem_in_en   <= 1'b0;
    end else begin
      rx_ready    <= (st_nxt != SET_ADDR) && (st_nxt != WRITE);
      mem_addr_en <= (st_nxt == SET_ADDR);
      mem_in_en   <= (st_nxt == WRITE);
    end
  end

  // Frame datapath and status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r        <= 16'd0;
      idx_r        <= 16'd0;
      word_r       <= 16'd0;
      chk_r        <= '0;
      mem_addr     <= 16'd0;
      mem_in       <= 16'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= 16'd0;
    end else begin
      done <= 1'b0;
      if (abort_s) begin
        err  <= 1'b1;
        busy <= 1'b0;
      end else begin
        case (st_r)
          IDLE: begin
            if (acc_s && (rx_data == SYNC_BYTE)) begin
              busy         <= 1'b1;
              err          <= 1'b0;
              chk_r        <= '0;
              idx_r        <= 16'd0;
              words_loaded <= 16'd0;
            end
          end
          CNT_HI: begin
            if (acc_s) begin
              cnt_r[15:8] <= rx_data;
              chk_r       <= chk_update(chk_r, rx_data);
            end
          end
          CNT_LO: begin
            if (acc_s) begin
              cnt_r[7:0] <= rx_data;
              chk_r      <= chk_update(chk_r, rx_data);
              if (oversize_s) begin
                err  <= 1'b1;
                busy <= 1'b0;
              end
            end
          end
          DATA_HI: begin
            if (acc_s) begin
              word_r[15:8] <= rx_data;
              chk_r        <= chk_update(chk_r, rx_data);
            end
          end
          DATA_LO: begin
            if (acc_s) begin
              word_r[7:0] <= rx_data;
              chk_r       <= chk_update(chk_r, rx_data);
              mem_addr    <= BASE_ADDR + idx_r;
            end
          end
          SET_ADDR: mem_in <= word_r;
          WRITE: begin
            idx_r <= idx_r + 16'd1;
            if (words_loaded < cnt_r) begin
              words_loaded <= words_loaded + 16'd1;
            end
          end
          CHECK: begin
            if (acc_s) begin
              busy <= 1'b0;
              if (rx_data == chk_r) begin
                done <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end
          end
          default: busy <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader with a small model of the target memory.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, mem_addr_en, mem_in_en, busy, done, err;
  logic [15:0] mem_addr, mem_in, words_loaded;

  int total = 0;
  int bad   = 0;

  // memory model and strobe monitors
  logic [15:0] tmem [0:255];
  logic [15:0] lat_addr;
  logic        prev_aen;
  int naddr, nin, ndone, rdy_low, order_bad;

  always #5 clk = ~clk;

  mem_loader #(.TIMEOUT_CYCLES(50)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .mem_addr_en  (mem_addr_en),
    .mem_addr     (mem_addr),
    .mem_in_en    (mem_in_en),
    .mem_in       (mem_in),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    naddr = 0; nin = 0; ndone = 0; rdy_low = 0; order_bad = 0;
  endtask

  // drive one byte at a negedge and hold it until the loader takes it
  task automatic send(input logic [7:0] b);
    int   guard;
    logic took;
    rx_valid = 1'b1;
    rx_data  = b;
    guard    = 0;
    took     = 1'b0;
    while (!took && guard < 20) begin
      took = rx_ready;
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    if (!took) begin
      total++;
      bad++;
      $display("FAIL send_accept byte=%h observed=no_accept expected=accept", b);
    end
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tmem[i] = 16'h0000;
    lat_addr = 16'h0000;
    prev_aen = 1'b0;
    clr_mon();
    forever begin
      @(posedge clk);
      #3;
      if (!rx_ready) rdy_low++;
      if (mem_addr_en) begin
        lat_addr = mem_addr;
        naddr++;
      end
      if (mem_in_en) begin
        tmem[lat_addr[7:0]] = mem_in;
        nin++;
        if (!prev_aen) order_bad++;
      end else if (prev_aen) begin
        order_bad++;
      end
      if (done) ndone++;
      prev_aen = mem_addr_en;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "bench stalled");
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_flags", {26'd0, busy, done, err, mem_addr_en, mem_in_en, rx_ready}, 32'd0);
    check("rst_words", words_loaded, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_in", mem_in, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", rx_ready, 32'd1);

    // good frame: 00^02^12^34^AB^CD = 42
    clr_mon();
    send(8'hA5);
    check("sync_busy", busy, 32'd1);
    send(8'h00); send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
    send(8'h42);
    check("good_done", done, 32'd1);
    check("good_err", err, 32'd0);
    check("good_busy", busy, 32'd0);
    check("good_words", words_loaded, 32'd2);
    idle(4);
    check("good_done_once", ndone, 32'd1);
    check("good_nin", nin, 32'd2);
    check("good_naddr", naddr, 32'd2);
    check("good_order", order_bad, 32'd0);
    check("good_mem0", tmem[0], 32'h1234);
    check("good_mem1", tmem[1], 32'hABCD);
    check("good_rdy_low", rdy_low, 32'd4);

    // back-to-back 3-word frame: 00^03^11^22^33^44^55^66 = 74
    clr_mon();
    send(8'hA5); send(8'h00); send(8'h03);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55); send(8'h66);
    send(8'h74);
    check("b2b_done", done, 32'd1);
    check("b2b_words", words_loaded, 32'd3);
    idle(3);
    check("b2b_rdy_low", rdy_low, 32'd6);
    check("b2b_nin", nin, 32'd3);
    check("b2b_order", order_bad, 32'd0);
    check("b2b_mem0", tmem[0], 32'h1122);
    check("b2b_mem1", tmem[1], 32'h3344);
    check("b2b_mem2", tmem[2], 32'h5566);

    // bad checksum
    clr_mon();
    send(8'hA5); send(8'h00); send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
    send(8'h41);
    check("badchk_err", err, 32'd1);
    check("badchk_done", done, 32'd0);
    check("badchk_busy", busy, 32'd0);
    check("badchk_words", words_loaded, 32'd2);
    idle(3);
    check("badchk_sticky", err, 32'd1);
    check("badchk_ndone", ndone, 32'd0);
    check("badchk_nin", nin, 32'd2);
    check("badchk_mem1", tmem[1], 32'hABCD);
    check("badchk_mem2", tmem[2], 32'h5566);

    // oversize count 257
    clr_mon();
    send(8'hA5);
    check("over_err_clr", err, 32'd0);
    check("over_busy", busy, 32'd1);
    send(8'h01); send(8'h01);
    check("over_err", err, 32'd1);
    check("over_busy_drop", busy, 32'd0);
    idle(3);
    check("over_naddr", naddr, 32'd0);
    check("over_nin", nin, 32'd0);
    check("over_ready", rx_ready, 32'd1);

    // timeout after one data byte, 50 idle clocks
    clr_mon();
    send(8'hA5); send(8'h00); send(8'h01); send(8'h12);
    idle(49);
    check("tmo_err_early", err, 32'd0);
    check("tmo_busy_early", busy, 32'd1);
    @(negedge clk);
    check("tmo_err", err, 32'd1);
    check("tmo_busy", busy, 32'd0);
    check("tmo_nin", nin, 32'd0);
    check("tmo_naddr", naddr, 32'd0);
    // recovery frame: 00^01^BE^EF = 50
    send(8'hA5);
    check("rec_err_clr", err, 32'd0);
    send(8'h00); send(8'h01); send(8'hBE); send(8'hEF); send(8'h50);
    check("rec_done", done, 32'd1);
    idle(3);
    check("rec_mem0", tmem[0], 32'hBEEF);
    check("rec_nin", nin, 32'd1);

    // count 256 is accepted, then reset after the third data byte
    clr_mon();
    send(8'hA5); send(8'h01); send(8'h00);
    check("max_err", err, 32'd0);
    check("max_busy", busy, 32'd1);
    send(8'h12); send(8'h34); send(8'h56);
    check("max_words", words_loaded, 32'd1);
    check("max_mem0", tmem[0], 32'h1234);
    rst = 1'b1;
    #1;
    check("mid_rst_flags", {26'd0, busy, done, err, mem_addr_en, mem_in_en, rx_ready}, 32'd0);
    check("mid_rst_words", words_loaded, 32'd0);
    check("mid_rst_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    clr_mon();
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    check("zero_done", done, 32'd1);
    check("zero_words", words_loaded, 32'd0);
    check("zero_err", err, 32'd0);
    check("zero_busy", busy, 32'd0);
    idle(3);
    check("zero_ndone", ndone, 32'd1);
    check("zero_nin", nin, 32'd0);
    check("zero_mem0", tmem[0], 32'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
